// File: rtl/spi_target_pkg.sv
// Shared types and field widths for the SPI target register block.
package spi_target_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR,
    ST_RD
  } spi_tgt_state_e;

  localparam int CmdRwBit  = 7;
  localparam int AddrWidth = 7;
  localparam int ByteWidth = 8;

endpackage

// File: rtl/spi_target_sync.sv
// Multi-stage pin synchronizer with registered rise/fall detect; level_o is aligned with the edge pulses.
module spi_target_sync #(
  parameter int   SyncStages = 2,
  parameter logic RstVal     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SyncStages-1:0] sync_q;
  logic                  prev_q;
  logic                  sync_last;

  assign sync_last = sync_q[SyncStages-1];
  assign level_o   = prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SyncStages{RstVal}};
      prev_q <= RstVal;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync_q[0] <= pin_i;
      for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_last;
      rise_o <= sync_last & ~prev_q;
      fall_o <= ~sync_last & prev_q;
    end
  end

endmodule

// File: rtl/spi_target_regs.sv
// Mode-0 SPI target with a byte-wide register file; all SPI pins oversampled in clk_i.
//   state   | meaning
//   ST_IDLE | CSB high, MISO released
//   ST_CMD  | shifting in command byte {rw, addr}
//   ST_WR   | shifting in write data bytes
//   ST_RD   | shifting out read data bytes
module spi_target_regs
  import spi_target_pkg::*;
#(
  parameter int                   NumRegs    = 16,
  parameter int                   SyncStages = 2,
  parameter logic [ByteWidth-1:0] RegRstVal  = 8'h00
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         spi_sck_i,
  input  logic                         spi_csb_i,
  input  logic                         spi_sd_i,
  output logic                         spi_sd_o,
  output logic                         spi_sd_en_o,
  output logic [NumRegs*ByteWidth-1:0] regs_o,
  output logic                         wr_valid_o,
  output logic [AddrWidth-1:0]         wr_addr_o,
  output logic [ByteWidth-1:0]         wr_data_o,
  output logic                         busy_o
);

  logic sck_lvl, sck_rise, sck_fall;
  logic csb_lvl, csb_rise, csb_fall;
  logic sd_lvl, sd_rise, sd_fall;

  spi_target_sync #(.SyncStages(SyncStages), .RstVal(1'b0)) u_sync_sck (
    .clk_i(clk_i), .rst_i(rst_i), .pin_i(spi_sck_i),
    .level_o(sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
  );
  spi_target_sync #(.SyncStages(SyncStages), .RstVal(1'b1)) u_sync_csb (
    .clk_i(clk_i), .rst_i(rst_i), .pin_i(spi_csb_i),
    .level_o(csb_lvl), .rise_o(csb_rise), .fall_o(csb_fall)
  );
  spi_target_sync #(.SyncStages(SyncStages), .RstVal(1'b0)) u_sync_sd (
    .clk_i(clk_i), .rst_i(rst_i), .pin_i(spi_sd_i),
    .level_o(sd_lvl), .rise_o(sd_rise), .fall_o(sd_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_lvl, csb_lvl, sd_rise, sd_fall};

  spi_tgt_state_e               state_q;
  logic [2:0]                   bit_cnt_q;
  logic [ByteWidth-1:0]         shift_q;
  logic [AddrWidth-1:0]         addr_q;
  logic [NumRegs*ByteWidth-1:0] regs_q;

  logic [ByteWidth-1:0] shift_in;
  logic [AddrWidth-1:0] cmd_addr;
  logic [AddrWidth-1:0] addr_inc;
  logic [ByteWidth-1:0] cmd_rd_byte;
  logic [ByteWidth-1:0] inc_rd_byte;
  logic                 addr_in_range;

  // Unmapped addresses read back as zero.
  function automatic logic [ByteWidth-1:0] reg_read(
    input logic [NumRegs*ByteWidth-1:0] regs,
    input logic [AddrWidth-1:0]         a
  );
    reg_read = '0;
    for (int k = 0; k < NumRegs; k++)
      if (a == AddrWidth'(k)) reg_read = regs[k*ByteWidth +: ByteWidth];
  endfunction

  assign shift_in      = {shift_q[ByteWidth-2:0], sd_lvl};
  assign cmd_addr      = shift_in[AddrWidth-1:0];
  assign addr_inc      = addr_q + 1'b1;
  assign cmd_rd_byte   = reg_read(regs_q, cmd_addr);
  assign inc_rd_byte   = reg_read(regs_q, addr_inc);
  assign addr_in_range = (32'(addr_q) < NumRegs);
  assign regs_o        = regs_q;
  assign busy_o        = (state_q != ST_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      addr_q      <= '0;
      regs_q      <= {NumRegs{RegRstVal}};
      spi_sd_o    <= 1'b0;
      spi_sd_en_o <= 1'b0;
      wr_valid_o  <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
    end else begin
      wr_valid_o <= 1'b0;
      // CSB release wins over any SCK edge seen in the same cycle.
      if (csb_rise) begin
        state_q     <= ST_IDLE;
        spi_sd_o    <= 1'b0;
        spi_sd_en_o <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (csb_fall) begin
              state_q   <= ST_CMD;
              bit_cnt_q <= '0;
            end
          end
          ST_CMD: begin
            if (sck_rise) begin
              shift_q   <= shift_in;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                addr_q <= cmd_addr;
                if (shift_in[CmdRwBit]) begin
                  state_q     <= ST_RD;
                  shift_q     <= cmd_rd_byte;
                  spi_sd_o    <= cmd_rd_byte[ByteWidth-1];
                  spi_sd_en_o <= 1'b1;
                end else begin
                  state_q <= ST_WR;
                end
              end
            end
          end
          ST_WR: begin
            if (sck_rise) begin
              shift_q   <= shift_in;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (addr_in_range) begin
                  for (int k = 0; k < NumRegs; k++)
                    if (addr_q == AddrWidth'(k)) regs_q[k*ByteWidth +: ByteWidth] <= shift_in;
                  wr_valid_o <= 1'b1;
                  wr_addr_o  <= addr_q;
                  wr_data_o  <= shift_in;
                end
                addr_q <= addr_inc;
              end
            end
          end
          ST_RD: begin
            if (sck_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                addr_q   <= addr_inc;
                shift_q  <= inc_rd_byte;
                spi_sd_o <= inc_rd_byte[ByteWidth-1];
              end
            // The falling edge right after a byte boundary keeps the freshly loaded MSB.
            end else if (sck_fall && (bit_cnt_q != 3'd0)) begin
              shift_q  <= {shift_q[ByteWidth-2:0], 1'b0};
              spi_sd_o <= shift_q[ByteWidth-2];
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_target_regs.sv
// Directed SPI host stimulus with scoreboard queues for register writes and MISO bytes.
module tb_spi_target_regs;

  logic         clk_i     = 1'b0;
  logic         rst_i     = 1'b1;
  logic         spi_sck_i = 1'b0;
  logic         spi_csb_i = 1'b1;
  logic         spi_sd_i  = 1'b0;
  logic         spi_sd_o;
  logic         spi_sd_en_o;
  logic [127:0] regs_o;
  logic         wr_valid_o;
  logic [6:0]   wr_addr_o;
  logic [7:0]   wr_data_o;
  logic         busy_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [14:0]  wr_exp[$];
  logic [7:0]   rd_exp[$];
  logic [127:0] exp_regs = '0;
  logic [7:0]   fbuf[0:7];

  always #5 clk_i = ~clk_i;

  spi_target_regs #(.NumRegs(16), .SyncStages(2), .RegRstVal(8'h00)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .spi_sck_i(spi_sck_i), .spi_csb_i(spi_csb_i), .spi_sd_i(spi_sd_i),
    .spi_sd_o(spi_sd_o), .spi_sd_en_o(spi_sd_en_o),
    .regs_o(regs_o),
    .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .busy_o(busy_o)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic push_wr(input logic [6:0] a, input logic [7:0] d);
    wr_exp.push_back({a, d});
    exp_regs[int'(a)*8 +: 8] = d;
  endtask

  task automatic csb_low();
    spi_csb_i = 1'b0;
    wait_clk(4);
  endtask

  task automatic csb_high();
    wait_clk(4);
    spi_csb_i = 1'b1;
    wait_clk(8);
  endtask

  // SCK = clk/8: 4 cycles low with MOSI set up, 4 cycles high.
  task automatic send_bits(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      spi_sd_i = fbuf[i/8][7-(i%8)];
      wait_clk(4);
      spi_sck_i = 1'b1;
      wait_clk(4);
      spi_sck_i = 1'b0;
    end
  endtask

  task automatic full_frame(input int nbytes);
    csb_low();
    send_bits(nbytes*8);
    csb_high();
  endtask

  // Write monitor
  always @(negedge clk_i) begin
    if (wr_valid_o === 1'b1) begin
      if (wr_exp.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_wr: got addr %0h data %0h, expected no write", wr_addr_o, wr_data_o);
      end else begin
        logic [14:0] e;
        e = wr_exp.pop_front();
        chk("wr_addr", 128'(wr_addr_o), 128'(e[14:8]));
        chk("wr_data", 128'(wr_data_o), 128'(e[7:0]));
        chk("wr_regs_o", 128'(regs_o[int'(e[14:8])*8 +: 8]), 128'(e[7:0]));
      end
    end
  end

  // MISO monitor: snoops the bus like the host would
  int         mb       = 0;
  logic       first_b  = 1'b1;
  logic       is_rd    = 1'b0;
  logic [7:0] mosi_sh  = '0;
  logic [7:0] miso_sh  = '0;

  always @(posedge spi_sck_i or posedge spi_csb_i) begin
    if (spi_csb_i) begin
      mb      = 0;
      first_b = 1'b1;
    end else if (!rst_i) begin
      mosi_sh = {mosi_sh[6:0], spi_sd_i};
      miso_sh = {miso_sh[6:0], spi_sd_o};
      mb++;
      if (mb == 8) begin
        mb = 0;
        if (first_b) begin
          first_b = 1'b0;
          is_rd   = mosi_sh[7];
        end else if (is_rd) begin
          if (rd_exp.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_rd: got byte %0h, expected none", miso_sh);
          end else begin
            chk("rd_byte", 128'(miso_sh), 128'(rd_exp.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    wait_clk(3);
    chk("rst_sd_o", 128'(spi_sd_o), 128'(0));
    chk("rst_sd_en", 128'(spi_sd_en_o), 128'(0));
    chk("rst_wr_valid", 128'(wr_valid_o), 128'(0));
    chk("rst_wr_addr", 128'(wr_addr_o), 128'(0));
    chk("rst_wr_data", 128'(wr_data_o), 128'(0));
    chk("rst_busy", 128'(busy_o), 128'(0));
    chk("rst_regs", regs_o, 128'h0);
    rst_i = 1'b0;
    wait_clk(5);

    // single write
    push_wr(7'd3, 8'hA5);
    fbuf[0] = 8'h03; fbuf[1] = 8'hA5;
    full_frame(2);
    chk("reg3_a5", 128'(regs_o[31:24]), 128'(8'hA5));

    // preload 14,15 by burst, then 0
    push_wr(7'd14, 8'h11);
    push_wr(7'd15, 8'h22);
    fbuf[0] = 8'h0E; fbuf[1] = 8'h11; fbuf[2] = 8'h22;
    full_frame(3);
    push_wr(7'd0, 8'h33);
    fbuf[0] = 8'h00; fbuf[1] = 8'h33;
    full_frame(2);

    // burst read across the end of the map
    rd_exp.push_back(8'h11); rd_exp.push_back(8'h22); rd_exp.push_back(8'h00);
    fbuf[0] = 8'h8E; fbuf[1] = 8'h00; fbuf[2] = 8'h00; fbuf[3] = 8'h00;
    full_frame(4);
    rd_exp.push_back(8'h33);
    fbuf[0] = 8'h80; fbuf[1] = 8'h00;
    full_frame(2);

    // out-of-range write and read
    fbuf[0] = 8'h40; fbuf[1] = 8'hFF;
    full_frame(2);
    chk("oor_regs_unchanged", regs_o, exp_regs);
    rd_exp.push_back(8'h00);
    fbuf[0] = 8'hC0; fbuf[1] = 8'h00;
    full_frame(2);

    // abort after 5 data bits
    fbuf[0] = 8'h05; fbuf[1] = 8'hFF;
    csb_low();
    send_bits(13);
    chk("abort_busy_before", 128'(busy_o), 128'(1));
    wait_clk(4);
    spi_csb_i = 1'b1;
    wait_clk(4);
    chk("abort_busy_after", 128'(busy_o), 128'(0));
    wait_clk(8);
    chk("abort_reg5", 128'(regs_o[47:40]), 128'(8'h00));

    // write burst wrapping 127 -> 0, then read burst across the wrap
    push_wr(7'd0, 8'hBB);
    fbuf[0] = 8'h7F; fbuf[1] = 8'hAA; fbuf[2] = 8'hBB;
    full_frame(3);
    rd_exp.push_back(8'h00); rd_exp.push_back(8'hBB);
    fbuf[0] = 8'hFF; fbuf[1] = 8'h00; fbuf[2] = 8'h00;
    full_frame(3);

    // async reset in the middle of a read byte
    fbuf[0] = 8'h80; fbuf[1] = 8'h00;
    csb_low();
    send_bits(12);
    chk("rd_en_before_rst", 128'(spi_sd_en_o), 128'(1));
    rst_i = 1'b1;
    #1;
    chk("rd_en_after_rst", 128'(spi_sd_en_o), 128'(0));
    chk("sd_o_after_rst", 128'(spi_sd_o), 128'(0));
    chk("busy_after_rst", 128'(busy_o), 128'(0));
    spi_csb_i = 1'b1;
    wait_clk(4);
    rst_i = 1'b0;
    exp_regs = '0;
    wait_clk(8);
    chk("regs_after_rst", regs_o, 128'h0);

    push_wr(7'd1, 8'h5A);
    fbuf[0] = 8'h01; fbuf[1] = 8'h5A;
    full_frame(2);
    rd_exp.push_back(8'h5A);
    fbuf[0] = 8'h81; fbuf[1] = 8'h00;
    full_frame(2);

    wait_clk(10);
    chk("regs_final", regs_o, exp_regs);
    chk("wr_pending", 128'(wr_exp.size()), 128'(0));
    chk("rd_pending", 128'(rd_exp.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_target_regs.md
# spi_target_regs

SPI target (responder) with a small byte-wide register file, the device-side counterpart of the SoC's SPI host on the FPGA target. An external SPI host (board MCU, second FPGA, or the SoC's own `spih_*` pins looped back for bring-up) reads and writes configuration bytes over mode-0 SPI. All SPI pins are oversampled in the single system clock domain; there is no SCK-clocked logic.

## Interface
- `NumRegs`, 16: number of 8-bit registers (1..128).
- `SyncStages`, 2: synchronizer depth on `spi_sck_i`, `spi_csb_i` and `spi_sd_i`.
- `RegRstVal`, 8'h00: reset value of every register.
- `clk_i` in 1: system clock (e.g. `soc_clk`, 50 MHz).
- `rst_i` in 1: asynchronous, active-high reset.
- `spi_sck_i` in 1: SPI clock from host, idle low (mode 0).
- `spi_csb_i` in 1: chip select, active low.
- `spi_sd_i` in 1: MOSI.
- `spi_sd_o` out 1: MISO data.
- `spi_sd_en_o` out 1: MISO output enable for the pad tristate (1 = drive).
- `regs_o` out NumRegs*8: register file, reg k at bits [8k+7:8k].
- `wr_valid_o` out 1: one-cycle pulse per completed register write.
- `wr_addr_o` out 7: address of that write.
- `wr_data_o` out 8: data of that write.
- `busy_o` out 1: high while a transaction is active (synced CSB low).

## Operation
- Frame: CSB low, byte 0 = command {R/W (1 = read), addr[6:0]}, then any number of data bytes, MSB first. Address auto-increments after each data byte; wraps 127 -> 0.
- Mode 0: target samples MOSI on SCK rising edge, updates MISO on SCK falling edge.
- FSM states: IDLE, CMD, WR, RD.
  - IDLE -> CMD on synced CSB falling; bit counter cleared.
  - CMD: shift 8 bits; on 8th rising edge latch addr; go to WR or RD. For RD, load shift register with reg[addr] and drive its MSB on `spi_sd_o` immediately.
  - WR: on each 8th rising edge, if addr < NumRegs: write reg, pulse `wr_valid_o` with addr/data; else discard, no pulse. Then addr++.
  - RD: shift out on falling edges; after 8th rising edge, addr++ and reload from the new addr (including wrap) for the next byte. addr >= NumRegs reads 8'h00.
  - Any state -> IDLE on synced CSB rising; partial byte discarded, no write, no pulse.
- `spi_sd_en_o` = 1 only in RD; `spi_sd_o` = 0 whenever not in RD.
- Write then read of the same address in a later frame returns the written value; `regs_o` updates in the same cycle `wr_valid_o` pulses.

## Timing
- Reset values: FSM IDLE, `regs_o` all RegRstVal, `spi_sd_o` 0, `spi_sd_en_o` 0, `wr_valid_o` 0, `wr_addr_o` 0, `wr_data_o` 0, `busy_o` 0; synchronizer flops reset to idle levels (SCK 0, CSB 1, SD 0).
- Pin-to-edge-detect latency: SyncStages + 1 `clk_i` cycles.
- `wr_valid_o` asserts exactly 1 cycle after the detected 8th rising edge of a data byte.
- MISO changes within SyncStages + 2 cycles after an SCK falling edge at the pin.
- Supported SCK: f(clk_i)/8 maximum; each SCK high and low phase >= 4 `clk_i` cycles; CSB setup/hold to SCK >= 4 cycles. Faster SCK is unsupported (no error flag).
- SCK edges while CSB high are ignored. CSB edge and SCK edge detected in the same cycle: CSB takes priority.
- Reset asserted mid-frame: immediate return to IDLE; the frame is lost; host must re-toggle CSB.

## Structure
- `spi_target_pkg`: state enum `spi_tgt_state_e`, `CmdRwBit = 7`, `AddrWidth = 7`, `ByteWidth = 8`.
- Sub-module `spi_target_sync`: SyncStages-deep synchronizer plus rise/fall detect for SCK and CSB, synced SD; reused for all three pins.
- Top holds FSM, 3-bit bit counter, 8-bit shift register, 7-bit address counter, register array.

## Test plan
- Reset: assert `rst_i` -> all outputs at reset values; `regs_o` = all 8'h00.
- Single write: cmd 8'h03, data 8'hA5 at SCK = clk/8 -> one `wr_valid_o` pulse, addr 3, data A5; `regs_o[31:24]` = A5.
- Burst read with wrap (NumRegs = 16): preload regs 14,15,0 with 11,22,33; cmd 8'h8E, 3 bytes -> MISO 11,22,33? No: addr 16 is out of range -> MISO 11,22,00; then a read of cmd 8'h80 returns 33.
- Out of range: cmd 8'h40, data 8'hFF -> no `wr_valid_o`, `regs_o` unchanged; read of 8'hC0 -> 8'h00.
- Abort: cmd 8'h05, then CSB high after 5 data bits -> no write, FSM IDLE, `busy_o` 0 within SyncStages + 2 cycles.
- Async reset mid-read at bit 4 -> `spi_sd_en_o` 0 immediately; following full frame (write 8'h01/8'h5A, read back) succeeds with 5A.
